down_count_checker: RTL and testbench

DOWN_COUNT_CHECKER -- requirements
Module: down_count_checker

---
 rtl/down_count_checker_pkg.sv | 19 +
 rtl/down_count_checker_sat_counter8.sv | 24 ++
 rtl/down_count_checker.sv | 131 +++++++++++++
 tb/tb_down_count_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/down_count_checker_pkg.sv
// Shared definitions for the down-counter checker.
// Holds the FSM state encoding, the width of the 4-bit down counter being
// checked, and a small helper that computes the expected next counter value.
package down_count_checker_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Expected successor of a down-counter value; wraps 0 -> 15.
   function automatic logic [CNT_W-1:0] dec_cnt(input logic [CNT_W-1:0] v);
      return v - CNT_W'(1);
   endfunction

endpackage

// File: rtl/down_count_checker_sat_counter8.sv
// sat_counter8: 8-bit event counter that saturates at 8'hFF.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears count
//   clear - synchronous clear of count, wins over inc
//   inc   - add one to count this cycle (ignored once saturated)
//   count - current count value
module sat_counter8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= 8'd0;
      end else if (inc && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/down_count_checker.sv
// down_count_checker: monitors a sampled 4-bit down counter and tracks lock.
// A SEARCH/SYNC/LOCKED FSM follows the qualified samples: LOCK_N consecutive
// correct decrements lock it, LOSS_N consecutive mismatches while locked drop
// it back to SEARCH. Cycles with valid=0 change nothing.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, discards all history
//   in        - sampled counter value
//   valid     - qualifies in
//   clear     - synchronous clear of err_count
//   locked    - high while the FSM is LOCKED
//   error     - one-cycle pulse for a mismatch seen while LOCKED
//   wrap      - one-cycle pulse for a correct 0 -> 15 step while LOCKED
//   err_count - saturating count of error pulses
module down_count_checker
   import down_count_checker_pkg::*;
#(
   parameter int LOCK_N = 3,
   parameter int LOSS_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] in,
   input  logic             valid,
   input  logic             clear,
   output logic             locked,
   output logic             error,
   output logic             wrap,
   output logic [7:0]       err_count
);

   localparam logic [3:0] LOCK_C = 4'(LOCK_N);
   localparam logic [3:0] LOSS_C = 4'(LOSS_N);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] prev, prev_nxt;
   logic [3:0]       run, run_nxt;
   logic [3:0]       miss, miss_nxt;
   logic             error_nxt, wrap_nxt;
   logic             match, mismatch;
   logic [3:0]       run_inc, miss_inc;

   assign match    = valid && (in == dec_cnt(prev));
   assign mismatch = valid && (in != dec_cnt(prev));
   assign run_inc  = run + 4'd1;
   assign miss_inc = miss + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SEARCH;
         prev   <= '0;
         run    <= '0;
         miss   <= '0;
         locked <= 1'b0;
         error  <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         state  <= state_nxt;
         prev   <= prev_nxt;
         run    <= run_nxt;
         miss   <= miss_nxt;
         // Loaded from the next state so locked always equals (state == LOCKED).
         locked <= (state_nxt == LOCKED);
         error  <= error_nxt;
         wrap   <= wrap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      run_nxt   = run;
      miss_nxt  = miss;
      error_nxt = 1'b0;
      wrap_nxt  = 1'b0;
      case (state)
         SEARCH: begin
            // First qualified sample is only captured, never compared.
            if (valid) begin
               prev_nxt  = in;
               run_nxt   = '0;
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            if (valid) begin
               prev_nxt = in;
               if (match) begin
                  run_nxt = run_inc;
                  if (run_inc == LOCK_C) begin
                     state_nxt = LOCKED;
                     miss_nxt  = '0;
                  end
               end else begin
                  run_nxt = '0;
               end
            end
         end
         LOCKED: begin
            if (valid) begin
               prev_nxt = in;
               if (match) begin
                  miss_nxt = '0;
                  wrap_nxt = (prev == '0);
               end else begin
                  // The mismatch that causes loss of lock still reports an error.
                  error_nxt = 1'b1;
                  miss_nxt  = miss_inc;
                  if (miss_inc == LOSS_C) begin
                     state_nxt = SEARCH;
                  end
               end
            end
         end
         default: begin
            state_nxt = SEARCH;
         end
      endcase
   end

   // Counting the error event on the edge that raises error keeps err_count
   // in step with the pulse.
   sat_counter8 u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (error_nxt),
      .count (err_count)
   );

endmodule

// File: tb/tb_down_count_checker.sv
module tb_down_count_checker;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_v;
   logic       valid;
   logic       clear;
   logic       locked;
   logic       error;
   logic       wrap;
   logic [7:0] err_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   down_count_checker #(.LOCK_N(3), .LOSS_N(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_v),
      .valid     (valid),
      .clear     (clear),
      .locked    (locked),
      .error     (error),
      .wrap      (wrap),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one qualified sample; returns #1 after the edge that took it.
   task automatic sample(input logic [3:0] d);
      valid = 1'b1;
      in_v  = d;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reset then lock on F,E,D,C; prev ends at C.
   task automatic lock_up();
      do_reset();
      sample(4'hF);
      sample(4'hE);
      sample(4'hD);
      sample(4'hC);
   endtask

   logic [3:0] p;
   logic [3:0] x;
   int         exp_cnt;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      clear = 1'b0;
      in_v  = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_locked", locked, 0);
      check("rst_error", error, 0);
      check("rst_wrap", wrap, 0);
      check("rst_errcnt", err_count, 0);

      // Lock-up: F capture, E/D matches, C completes LOCK_N=3.
      sample(4'hF);
      check("lk_F_locked", locked, 0);
      sample(4'hE);
      sample(4'hD);
      check("lk_D_locked", locked, 0);
      sample(4'hC);
      check("lk_C_locked", locked, 1);
      check("lk_error", error, 0);
      check("lk_errcnt", err_count, 0);

      // Wrap: count down to 1, then 1,0,F,E.
      for (int v = 11; v >= 2; v--) sample(4'(v));
      sample(4'h1);
      check("wr_1", wrap, 0);
      sample(4'h0);
      check("wr_0", wrap, 0);
      sample(4'hF);
      check("wr_F", wrap, 1);
      check("wr_F_err", error, 0);
      sample(4'hE);
      check("wr_E", wrap, 0);
      check("wr_errcnt", err_count, 0);

      // Glitch: reach A, then 9,8 match, 3 and 6 mismatch -> loss of lock.
      sample(4'hD); sample(4'hC); sample(4'hB); sample(4'hA);
      sample(4'h9);
      sample(4'h8);
      check("gl_8_err", error, 0);
      sample(4'h3);
      check("gl_3_err", error, 1);
      check("gl_3_cnt", err_count, 1);
      check("gl_3_locked", locked, 1);
      sample(4'h6);
      check("gl_6_err", error, 1);
      check("gl_6_cnt", err_count, 2);
      check("gl_6_locked", locked, 0);
      idle(1);
      check("gl_err_pulse", error, 0);

      // Saturation: mismatch/match pairs keep lock while counting errors.
      lock_up();
      p = 4'hC;
      exp_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         x = p - 4'd3;
         sample(x);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         check("sat_err", error, 1);
         check("sat_cnt", err_count, exp_cnt);
         sample(x - 4'd1);
         check("sat_locked", locked, 1);
         p = x - 4'd1;
      end
      check("sat_final", err_count, 8'hFF);
      clear = 1'b1;
      sample(p - 4'd5);
      clear = 1'b0;
      check("clr_cnt", err_count, 0);
      check("clr_err", error, 1);
      check("clr_locked", locked, 1);

      // Reset mid-operation with err_count=5.
      lock_up();
      p = 4'hC;
      for (int i = 0; i < 5; i++) begin
         x = p - 4'd3;
         sample(x);
         sample(x - 4'd1);
         p = x - 4'd1;
      end
      check("mid_cnt5", err_count, 5);
      check("mid_locked", locked, 1);
      do_reset();
      check("mid_locked0", locked, 0);
      check("mid_err0", error, 0);
      check("mid_wrap0", wrap, 0);
      check("mid_cnt0", err_count, 0);
      sample(4'h7);
      check("mid_7_err", error, 0);
      check("mid_7_locked", locked, 0);
      sample(4'h1);
      check("sync_mis_err", error, 0);
      check("sync_mis_cnt", err_count, 0);

      // Valid gaps: sample 5, ten idle cycles with in=A, then 4.
      lock_up();
      for (int v = 11; v >= 5; v--) sample(4'(v));
      in_v = 4'hA;
      idle(10);
      check("gap_err", error, 0);
      check("gap_locked", locked, 1);
      sample(4'h4);
      check("gap_4_err", error, 0);
      check("gap_4_locked", locked, 1);
      check("gap_cnt", err_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
